sd_clk_rate_ctrl: RTL and testbench

//  Sequences the clock-divider count generator and owns the SD card clock (sd_clk).

---
 rtl/sd_clk_rate_ctrl.sv | 148 ++++++++++++++
 tb/tb_sd_clk_rate_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_rate_ctrl.sv
// SD card clock owner: free-running sd_clk divider plus the speed-change sequencer.
// Define SD_CLK_STOP_EN to add the clk_stop input (sd_clk parked low while asserted).
module sd_clk_rate_ctrl #(
    parameter logic [15:0] INIT_COUNT = 16'd125,
    parameter logic [15:0] MIN_COUNT  = 16'd2,
    parameter int          WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_speed,
    input  logic [7:0]  tran_speed,
`ifdef SD_CLK_STOP_EN
    input  logic        clk_stop,
`endif
    output logic        div_start,
    output logic [7:0]  div_speed,
    input  logic        div_ok,
    input  logic        div_err,
    input  logic [15:0] div_count,
    output logic        sd_clk,
    output logic        sd_rise,
    output logic        sd_fall,
    output logic [15:0] cur_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] SWITCH = 3'd3;
    localparam logic [2:0] FAIL   = 3'd4;

    localparam int             WW        = $clog2(WAIT_LIMIT + 1);
    // REQ and FAIL cycles count toward the limit, so error lands WAIT_LIMIT cycles after div_start
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_LIMIT - 2);

    logic [2:0]    state;
    logic [15:0]   phase;
    logic [15:0]   pending;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   hi_len;
    logic [15:0]   lo_len;
    logic          stop;
    logic          end_lo;
    logic          end_hi;
    logic          switch_now;

`ifdef SD_CLK_STOP_EN
    assign stop = clk_stop;
`else
    assign stop = 1'b0;
`endif

    assign hi_len     = cur_count >> 1;
    assign lo_len     = cur_count - hi_len;
    assign end_lo     = !sd_clk && !stop && (phase == lo_len - 16'd1);
    assign end_hi     = sd_clk && (phase == hi_len - 16'd1);
    assign switch_now = (state == SWITCH) && end_lo;

    assign div_start  = (state == REQ);
    assign busy       = (state != RUN);

    // A pending switch replaces the rise, so the new low phase starts with no runt pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_clk    <= 1'b0;
            sd_rise   <= 1'b0;
            sd_fall   <= 1'b0;
            phase     <= '0;
            cur_count <= INIT_COUNT;
        end else begin
            sd_rise <= 1'b0;
            sd_fall <= 1'b0;
            if (switch_now) begin
                cur_count <= pending;
                phase     <= '0;
            end else if (end_lo) begin
                sd_clk  <= 1'b1;
                sd_rise <= 1'b1;
                phase   <= '0;
            end else if (end_hi) begin
                sd_clk  <= 1'b0;
                sd_fall <= 1'b1;
                phase   <= '0;
            end else if (!sd_clk && stop) begin
                phase <= '0;
            end else begin
                phase <= phase + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            div_speed <= '0;
            pending   <= '0;
            wait_cnt  <= '0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (set_speed) begin
                        div_speed <= tran_speed;
                        error     <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    wait_cnt <= WW'(1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (div_err) begin
                        state <= FAIL;
                    end else if (div_ok) begin
                        if (div_count >= MIN_COUNT) begin
                            pending <= div_count;
                            state   <= SWITCH;
                        end else begin
                            state <= FAIL;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= FAIL;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                SWITCH: begin
                    if (switch_now) begin
                        done  <= 1'b1;
                        state <= RUN;
                    end
                end
                FAIL: begin
                    error <= 1'b1;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_clk_rate_ctrl.sv
// Randomized bench for sd_clk_rate_ctrl: transaction-level request checks plus an
// arithmetic sd_clk model (sd_clk = position within period >= low length).
module tb_sd_clk_rate_ctrl;

    localparam int K_OK   = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_speed = 1'b0;
    logic [7:0]  tran_speed = '0;
    logic        div_ok = 1'b0;
    logic        div_err = 1'b0;
    logic [15:0] div_count = '0;
    logic        div_start;
    logic [7:0]  div_speed;
    logic        sd_clk;
    logic        sd_rise;
    logic        sd_fall;
    logic [15:0] cur_count;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk = 0;
    int n_fail = 0;

    // sd_clk model: edges since the current period segment began, and its period
    int m_n = 0;
    int m_seg = 0;
    int m_cnt = 125;
    int m_done_n = -1;
    int m_done_id = 0;
    int arm_id = 0;
    int arm_cnt = 0;
    int starts = 0;
    int s0 = 0;

    sd_clk_rate_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .set_speed  (set_speed),
        .tran_speed (tran_speed),
`ifdef SD_CLK_STOP_EN
        .clk_stop   (1'b0),
`endif
        .div_start  (div_start),
        .div_speed  (div_speed),
        .div_ok     (div_ok),
        .div_err    (div_err),
        .div_count  (div_count),
        .sd_clk     (sd_clk),
        .sd_rise    (sd_rise),
        .sd_fall    (sd_fall),
        .cur_count  (cur_count),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit armed();
        return arm_id != m_done_id;
    endfunction

    function automatic logic [31:0] exp_vec();
        int t, l, ph;
        logic sd, ri, fa, dn;
        t  = m_n - m_seg;
        l  = m_cnt - m_cnt / 2;
        ph = t % m_cnt;
        sd = (ph >= l);
        ri = (ph == l);
        fa = (t > 0) && (ph == 0);
        dn = (m_done_n == m_n);
        return {12'd0, sd, ri, fa, dn, 16'(m_cnt)};
    endfunction

    always @(posedge clk) begin
        m_n++;
        if (reset) begin
            m_seg     = m_n;
            m_cnt     = 125;
            m_done_id = arm_id;
        end else if (armed() && ((m_n - m_seg) % m_cnt) == (m_cnt - m_cnt / 2)) begin
            m_seg     = m_n;
            m_cnt     = arm_cnt;
            m_done_id = arm_id;
            m_done_n  = m_n;
        end
    end

    always @(negedge clk) begin
        if (div_start === 1'b1) starts++;
        if (!reset) chk("clk", {12'd0, sd_clk, sd_rise, sd_fall, done, cur_count}, exp_vec());
    end

    // Called on the negedge where reset was released
    task automatic meas_first();
        int k;
        k = 0;
        while (sd_clk !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("first_rise", k, 63);
        k = 0;
        while (sd_clk === 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("high_len", k, 62);
    endtask

    task automatic start_req(input logic [7:0] tr);
        @(negedge clk);
        chk("idle", busy, 0);
        s0         = starts;
        set_speed  = 1'b1;
        tran_speed = tr;
        @(negedge clk);
        set_speed  = 1'b0;
        tran_speed = 8'($urandom);
        chk("start", div_start, 1);
        chk("speed", div_speed, tr);
        chk("err_clr", error, 0);
        chk("busy", busy, 1);
        @(negedge clk);
        chk("start_end", div_start, 0);
        chk("speed_hold", div_speed, tr);
    endtask

    // Entered on the negedge of the first WAIT cycle
    task automatic respond(input int kind, input int d, input logic [15:0] cnt,
                           input bit poke, input bit hold);
        int lim;
        repeat (d) begin
            set_speed = poke && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        set_speed = 1'b0;
        div_ok    = (kind != K_ERR);
        div_err   = (kind != K_OK);
        div_count = cnt;
        @(negedge clk);
        div_ok    = 1'b0;
        div_err   = 1'b0;
        div_count = 16'($urandom);
        chk("busy_resp", busy, 1);
        if (kind == K_OK && cnt >= 16'd2) begin
            arm_cnt = int'(cnt);
            arm_id++;
            if (hold) return;
            lim = 2 * m_cnt + 4;
            for (int k = 0; k < lim && armed(); k++) begin
                set_speed = poke && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            set_speed = 1'b0;
            chk("switch_wait", armed(), 0);
            chk("busy_done", busy, 0);
            chk("err_ok", error, 0);
        end else begin
            chk("err_pre", error, 0);
            @(negedge clk);
            chk("err_set", error, 1);
            chk("busy_fail", busy, 0);
        end
        chk("one_start", starts, s0 + 1);
    endtask

    task automatic timeout_req(input logic [7:0] tr);
        start_req(tr);
        repeat (62) @(negedge clk);
        chk("tmo_pre_err", error, 0);
        chk("tmo_pre_busy", busy, 1);
        @(negedge clk);
        chk("tmo_err", error, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_start", starts, s0 + 1);
    endtask

    initial begin
        int kind, k;
        logic [15:0] cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vec", {sd_clk, sd_rise, sd_fall, div_start, busy, done, error}, 7'd0);
        chk("rst_speed", div_speed, 0);
        chk("rst_count", cur_count, 125);
        reset = 1'b0;
        meas_first();

        start_req(8'h00);
        respond(K_ERR, 3, 16'd0, 1'b1, 1'b0);
        chk("err_keep_count", cur_count, 125);
        start_req(8'h32);
        respond(K_OK, 0, 16'd2, 1'b0, 1'b0);
        chk("count2", cur_count, 2);
        timeout_req(8'h5a);
        start_req(8'h11);
        respond(K_BOTH, 5, 16'd50, 1'b0, 1'b0);
        start_req(8'h12);
        respond(K_OK, 2, 16'd1, 1'b0, 1'b0);
        start_req(8'h13);
        respond(K_OK, 61, 16'd3, 1'b1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 9) begin
                timeout_req(8'($urandom));
            end else begin
                cnt = (kind == 8) ? 16'($urandom_range(0, 1)) : 16'($urandom_range(2, 200));
                start_req(8'($urandom));
                respond((kind == 6) ? K_ERR : (kind == 7) ? K_BOTH : K_OK,
                        $urandom_range(0, 61), cnt, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        // Reset while a switch is pending and sd_clk is high
        start_req(8'h20);
        respond(K_OK, 0, 16'd40, 1'b0, 1'b0);
        k = 0;
        while (sd_clk !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        start_req(8'h21);
        respond(K_OK, 0, 16'd90, 1'b0, 1'b1);
        chk("pre_rst_clk", sd_clk, 1);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_count", cur_count, 40);
        #2 reset = 1'b1;
        #1;
        chk("rst_clk", sd_clk, 0);
        chk("rst_count2", cur_count, 125);
        chk("rst_flags", {busy, done, error, div_start}, 4'd0);
        chk("rst_speed2", div_speed, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_done", done, 0);
        reset = 1'b0;
        meas_first();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
